// File: rtl/sa_accept_prob_pipe.sv
// -----------------------------------------------------------------------------
// sa_accept_prob_pipe
//
// Pipelined Metropolis acceptance unit for the simulated-annealing TSP core.
// Computes p = exp(-(cost_new - cost_old) * tinv) in fixed point as
// 2^-(delta * tinv * log2(e)). The integer part of the exponent becomes a right
// shift, and the top LUT_BITS fraction bits index a 2^-f table.
// One candidate per cycle, valid/ready on both sides, tag passthrough.
// Four register stages, so latency is 4 cycles when not stalled.
//
// Optional build macro: SA_ACCEPT_EN
//   When defined, adds rand_in (sampled with the candidate and carried with it)
//   and accept = one || (prob > rand_in). When undefined, those ports are absent
//   and the caller compares prob itself.
//
// Ports
//   clk        in   1      clock
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      candidate valid
//   in_ready   out  1      unit can take a candidate this cycle (combinational from out_ready)
//   cost_new   in   DW     candidate tour cost (unsigned)
//   cost_old   in   DW     current tour cost (unsigned)
//   tinv       in   TW     1/T, UQ(TW-TF).TF
//   in_tag     in   TAG_W  sideband, returned unchanged
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   prob       out  PW     exp(-delta*tinv), UQ0.PW, 1.0 saturates to all-ones
//   out_tag    out  TAG_W  tag of this result
//   rand_in    in   PW     (SA_ACCEPT_EN only) uniform random threshold
//   accept     out  1      (SA_ACCEPT_EN only) acceptance decision
// -----------------------------------------------------------------------------
module sa_accept_prob_pipe #(
   parameter int DW       = 32,
   parameter int TW       = 32,
   parameter int TF       = 16,
   parameter int PW       = 16,
   parameter int LUT_BITS = 6,
   parameter int TAG_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    cost_new,
   input  logic [DW-1:0]    cost_old,
   input  logic [TW-1:0]    tinv,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PW-1:0]    prob,
   output logic [TAG_W-1:0] out_tag
`ifdef SA_ACCEPT_EN
   ,
   input  logic [PW-1:0]    rand_in,
   output logic             accept
`endif
);

   localparam int XW    = DW + TW;                 // |delta| * tinv, TF fraction bits
   localparam int LW    = 17;                      // width of log2(e) constant
   localparam logic [LW-1:0] LOG2E = 17'd94548;    // log2(e) in UQ1.16
   localparam int YW    = XW + LW;                 // full exponent width
   localparam int YF    = TF + 16;                 // exponent fraction bits
   localparam int YTW   = YW - (YF - LUT_BITS);    // exponent with only LUT_BITS fraction kept
   localparam int KB    = $clog2(PW);              // shift amounts that can leave a nonzero result
   localparam int LUT_N = 1 << LUT_BITS;

   // Table entry i = round(2^-(i/LUT_N) * 2^PW); entry 0 (exactly 1.0) saturates.
   function automatic logic [PW-1:0] lut_entry(input int idx);
      real    r;
      longint v;
      longint vmax;
      r    = (2.0 ** (-real'(idx) / real'(LUT_N))) * (2.0 ** PW);
      v    = longint'($rtoi(r + 0.5));
      vmax = (longint'(1) << PW) - 1;
      if (v > vmax) begin
         v = vmax;
      end
      return v[PW-1:0];
   endfunction

   logic [PW-1:0] lut [LUT_N];

   genvar gi;
   generate
      for (gi = 0; gi < LUT_N; gi++) begin : g_lut
         assign lut[gi] = lut_entry(gi);
      end
   endgenerate

   // Global stall: every stage holds while an output result is waiting.
   logic en;
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   // ---------------- stage registers ----------------
   logic                 s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic                 s1_one_reg,   s2_one_reg,   s3_one_reg;
   logic signed [DW:0]   s1_delta_reg;
   logic [TW-1:0]        s1_tinv_reg;
   logic [XW-1:0]        s2_x_reg;
   logic                 s3_zero_reg;
   logic [KB-1:0]        s3_k_reg;
   logic [LUT_BITS-1:0]  s3_f_reg;
   logic [TAG_W-1:0]     s1_tag_reg,   s2_tag_reg,   s3_tag_reg;
`ifdef SA_ACCEPT_EN
   logic [PW-1:0]        s1_rand_reg,  s2_rand_reg,  s3_rand_reg;
`endif

   // ---------------- stage 1 combinational ----------------
   logic signed [DW:0] delta_c;
   logic               one_c;
   assign delta_c = $signed({1'b0, cost_new}) - $signed({1'b0, cost_old});
   assign one_c   = delta_c[DW] || (delta_c == '0);

   // ---------------- stage 2 combinational ----------------
   logic [DW:0]   delta_neg_c;
   logic [DW:0]   mag_c;
   logic [XW-1:0] x_c;
   assign delta_neg_c = -s1_delta_reg;
   // Negative deltas are flagged as "one" and ignored later; magnitude kept for uniformity.
   assign mag_c = s1_delta_reg[DW] ? delta_neg_c : s1_delta_reg;
   assign x_c   = XW'(mag_c) * XW'(s1_tinv_reg);

   // ---------------- stage 3 combinational ----------------
   // Only LUT_BITS fraction bits of the exponent matter; lower bits are truncated away.
   logic [YTW-1:0]      yt_c;
   logic                k_big_c;
   logic [KB-1:0]       k_lo_c;
   logic                zero_c;
   assign yt_c    = YTW'((YW'(s2_x_reg) * YW'(LOG2E)) >> (YF - LUT_BITS));
   assign k_big_c = |yt_c[YTW-1:LUT_BITS+KB];
   assign k_lo_c  = yt_c[LUT_BITS+KB-1:LUT_BITS];
   // Any set bit above the shift range forces zero, so a huge exponent never wraps.
   assign zero_c  = k_big_c || ({1'b0, k_lo_c} >= (KB+1)'(PW));

   // ---------------- stage 4 combinational ----------------
   logic [PW-1:0] prob_c;
   always_comb begin
      prob_c = '0;
      if (s3_one_reg) begin
         prob_c = '1;
      end else if (!s3_zero_reg) begin
         prob_c = lut[s3_f_reg] >> s3_k_reg;
      end
   end

`ifdef SA_ACCEPT_EN
   logic accept_c;
   assign accept_c = s3_one_reg || (prob_c > s3_rand_reg);
`endif

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s3_valid_reg <= 1'b0;
         out_valid    <= 1'b0;
         s1_one_reg   <= 1'b0;
         s2_one_reg   <= 1'b0;
         s3_one_reg   <= 1'b0;
         s1_delta_reg <= '0;
         s1_tinv_reg  <= '0;
         s2_x_reg     <= '0;
         s3_zero_reg  <= 1'b0;
         s3_k_reg     <= '0;
         s3_f_reg     <= '0;
         s1_tag_reg   <= '0;
         s2_tag_reg   <= '0;
         s3_tag_reg   <= '0;
         prob         <= '0;
         out_tag      <= '0;
`ifdef SA_ACCEPT_EN
         s1_rand_reg  <= '0;
         s2_rand_reg  <= '0;
         s3_rand_reg  <= '0;
         accept       <= 1'b0;
`endif
      end else if (en) begin
         // S1: signed difference, "always accept" flag, operands
         s1_valid_reg <= in_valid;
         s1_one_reg   <= one_c;
         s1_delta_reg <= delta_c;
         s1_tinv_reg  <= tinv;
         s1_tag_reg   <= in_tag;
         // S2: |delta| * tinv
         s2_valid_reg <= s1_valid_reg;
         s2_one_reg   <= s1_one_reg;
         s2_x_reg     <= x_c;
         s2_tag_reg   <= s1_tag_reg;
         // S3: scale by log2(e), split into shift and table index
         s3_valid_reg <= s2_valid_reg;
         s3_one_reg   <= s2_one_reg;
         s3_zero_reg  <= zero_c;
         s3_k_reg     <= k_lo_c;
         s3_f_reg     <= yt_c[LUT_BITS-1:0];
         s3_tag_reg   <= s2_tag_reg;
         // S4: table lookup and shift into the output registers
         out_valid    <= s3_valid_reg;
         prob         <= prob_c;
         out_tag      <= s3_tag_reg;
`ifdef SA_ACCEPT_EN
         s1_rand_reg  <= rand_in;
         s2_rand_reg  <= s1_rand_reg;
         s3_rand_reg  <= s2_rand_reg;
         accept       <= s3_valid_reg && accept_c;
`endif
      end
   end

endmodule

// File: tb/tb_sa_accept_prob_pipe.sv
// -----------------------------------------------------------------------------
// tb_sa_accept_prob_pipe
//
// Directed self-checking bench for sa_accept_prob_pipe with PW=16, TF=16,
// LUT_BITS=6. Expected probabilities are hand-computed constants:
//   LUT[0]  saturates to 0xFFFF, LUT[28] = 48393 (0xBD09), LUT[32] = 46341 (0xB505).
// Outputs are sampled on the falling edge (plus #1 where combinational settling
// of in_ready matters).
// -----------------------------------------------------------------------------
module tb_sa_accept_prob_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] cost_new;
   logic [31:0] cost_old;
   logic [31:0] tinv;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] prob;
   logic [7:0]  out_tag;
   logic [15:0] rand_in;
   logic        accept;

   int n_cmp = 0;
   int n_err = 0;

   sa_accept_prob_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cost_new  (cost_new),
      .cost_old  (cost_old),
      .tinv      (tinv),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prob      (prob),
      .out_tag   (out_tag)
`ifdef SA_ACCEPT_EN
      ,
      .rand_in   (rand_in),
      .accept    (accept)
`endif
   );

`ifndef SA_ACCEPT_EN
   assign accept = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   // One isolated candidate: checks exact 4-cycle latency, prob, tag and accept.
   task automatic single(input string name, input logic [31:0] cn, input logic [31:0] co,
                         input logic [31:0] ti, input logic [7:0] tg,
                         input logic [15:0] exp_prob, input logic [15:0] rnd,
                         input logic exp_acc);
      @(negedge clk);
      in_valid = 1'b1;
      cost_new = cn;
      cost_old = co;
      tinv     = ti;
      in_tag   = tg;
      rand_in  = rnd;
      #1;
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);               // transfer edge
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({name, "_early_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);               // fourth edge after the transfer has passed
      check({name, "_out_valid"}, 64'(out_valid), 64'd1);
      check({name, "_prob"}, 64'(prob), 64'(exp_prob));
      check({name, "_tag"}, 64'(out_tag), 64'(tg));
`ifdef SA_ACCEPT_EN
      check({name, "_accept"}, 64'(accept), 64'(exp_acc));
`endif
      $display("txn %s: prob=0x%04h tag=0x%02h accept=%0d", name, prob, out_tag, accept);
   endtask

   initial begin
      logic [15:0] hold_prob;
      logic [7:0]  hold_tag;
      logic [15:0] exp_p;
      logic        hold_set;
      logic        seen;
      int          sent;
      int          got;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      cost_new  = '0;
      cost_old  = '0;
      tinv      = '0;
      in_tag    = '0;
      rand_in   = '0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_prob",      64'(prob),      64'd0);
      check("rst_out_tag",   64'(out_tag),   64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Acceptance-free regions and the basic function
      single("neg_delta",   32'd100,  32'd120,  32'h0001_0000, 8'h11, 16'hFFFF, 16'hFFFF, 1'b1);
      single("zero_delta",  32'd5000, 32'd5000, 32'hFFFF_FFFF, 8'h22, 16'hFFFF, 16'hFFFF, 1'b1);
      single("tinv_zero",   32'd6,    32'd5,    32'h0000_0000, 8'h23, 16'hFFFF, 16'hFFFF, 1'b0);
      single("k1_f0_acc",   32'd11,   32'd10,   32'h0000_B173, 8'h33, 16'h7FFF, 16'h7FFE, 1'b1);
      single("k1_f0_rej",   32'd11,   32'd10,   32'h0000_B173, 8'h34, 16'h7FFF, 16'h7FFF, 1'b0);
      single("k1_f28",      32'd11,   32'd10,   32'h0001_0000, 8'h35, 16'h5E84, 16'h0000, 1'b1);
      single("d2_half_t",   32'd12,   32'd10,   32'h0000_8000, 8'h36, 16'h5E84, 16'h5E84, 1'b0);
      single("k0_f32",      32'd11,   32'd10,   32'h0000_58BA, 8'h37, 16'hB505, 16'hB504, 1'b1);
      single("k15",         32'd11,   32'd10,   32'h000A_65B3, 8'h38, 16'h0001, 16'h0000, 1'b1);
      single("k16",         32'd11,   32'd10,   32'h000B_1726, 8'h39, 16'h0000, 16'h0000, 1'b0);
      single("k28",         32'd30,   32'd10,   32'h0001_0000, 8'h44, 16'h0000, 16'h0000, 1'b0);
      single("huge_nowrap", 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 8'h45, 16'h0000, 16'h0000, 1'b0);

      // Stream of 6 items, tag t uses delta=1, tinv=t*0xB173 -> prob = 0xFFFF >> t.
      // out_ready is low for cycles 4..6 while the first result waits.
      sent     = 0;
      got      = 0;
      hold_set = 1'b0;
      hold_prob = '0;
      hold_tag  = '0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc < 7);
         if (sent < 6) begin
            in_valid = 1'b1;
            cost_new = 32'd11;
            cost_old = 32'd10;
            tinv     = 32'(sent) * 32'h0000_B173;
            in_tag   = 8'(sent);
            rand_in  = '0;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready) begin
            check("stall_in_ready",  64'(in_ready),  64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            if (hold_set) begin
               check("stall_prob_hold", 64'(prob),    64'(hold_prob));
               check("stall_tag_hold",  64'(out_tag), 64'(hold_tag));
            end else begin
               hold_prob = prob;
               hold_tag  = out_tag;
               hold_set  = 1'b1;
            end
         end
         if (out_valid && out_ready) begin
            exp_p = 16'hFFFF;
            exp_p = exp_p >> got;
            check("stream_tag",  64'(out_tag), 64'(got));
            check("stream_prob", 64'(prob),    64'(exp_p));
            $display("txn stream: tag=%0d prob=0x%04h", out_tag, prob);
            got++;
         end
         if (in_valid && in_ready) begin
            sent++;
         end
      end
      check("stream_count", 64'(got), 64'd6);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("stream_no_dup", 64'(out_valid), 64'd0);

      // Reset with three items in flight, the first already at the output
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         cost_new = 32'd1;
         cost_old = 32'd2;
         tinv     = 32'h0001_0000;
         in_tag   = 8'(8'hA0 + i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("inflight_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_prob",  64'(prob),      64'd0);
      check("async_rst_tag",   64'(out_tag),   64'd0);
      check("async_rst_ready", 64'(in_ready),  64'd1);
      $display("txn reset: out_valid=%0d prob=0x%04h tag=0x%02h", out_valid, prob, out_tag);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("no_stale_after_rst", 64'(seen), 64'd0);

      single("post_rst", 32'd11, 32'd10, 32'h0000_B173, 8'h5A, 16'h7FFF, 16'h7FFE, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
